// File: rtl/dcache_dm_wb_pkg.sv
// dcache_dm_wb_pkg: shared widths and FSM encodings for the direct-mapped write-back cache
package dcache_dm_wb_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int IDX_W = 3;
  localparam int OFF_W = 2;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = DATA_W << OFF_W;
  localparam int LINES = 1 << IDX_W;
  typedef enum logic [1:0] {DC_IDLE = 2'd0, DC_WB = 2'd1, DC_FILL = 2'd2} dc_state_e;
endpackage

// File: rtl/dcache_dm_wb_array.sv
// dcache_dm_wb_array: tag/valid/dirty/data storage with combinational read, line write and word write
module dcache_dm_wb_array
  import dcache_dm_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [LINE_W-1:0] rd_line,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [DATA_W-1:0] word_data,
  input  logic              clr_dirty
);
  logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINE_W-1:0] data_mem [LINES];
  assign rd_tag = tag_mem[idx];
  assign rd_line = data_mem[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we) valid_d[idx] = 1'b1;
    if (line_we || clr_dirty) dirty_d[idx] = 1'b0;
    if (word_we) dirty_d[idx] = 1'b1;
  end
  always_ff @(posedge clk) begin
    valid_q <= rst ? '0 : valid_d;
    dirty_q <= rst ? '0 : dirty_d;
    if (line_we) begin
      tag_mem[idx] <= line_tag;
      data_mem[idx] <= line_data;
    end
    if (word_we) data_mem[idx][word_off*DATA_W +: DATA_W] <= word_data;
  end
endmodule

// File: rtl/dcache_dm_wb.sv
// dcache_dm_wb: direct-mapped write-back write-allocate data cache with line req/ack miss handling
module dcache_dm_wb
  import dcache_dm_wb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [LINE_W-1:0]       mem_wline,
  input  logic [LINE_W-1:0]       mem_rline,
  input  logic                    mem_ack,
  output logic [15:0]             miss_cnt
);
  dc_state_e state_q, state_d;
  logic gap_q, gap_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic [TAG_W-1:0] tag, v_tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [LINE_W-1:0] v_line;
  logic v_valid, v_dirty, req, hit, idle, in_wb, in_fill, ack, miss, line_we, word_we, clr_dirty;
  assign {tag, idx, off} = cpu_addr;
  assign req = cpu_rd | cpu_wr;
  assign hit = req & v_valid & (v_tag == tag);
  assign in_wb = state_q == DC_WB;
  assign in_fill = state_q == DC_FILL;
  assign idle = !in_wb && !in_fill;
  assign mem_req = !rst & !idle & !gap_q;
  assign mem_we = !rst & in_wb;
  assign mem_addr = in_wb ? {v_tag, idx} : cpu_addr[ADDR_W-1:OFF_W];
  assign mem_wline = v_line;
  assign ack = mem_req & mem_ack;
  assign miss = !rst & idle & req & !hit;
  assign cpu_stall = !rst & (idle ? req & !hit : 1'b1);
  assign cpu_rdata = (!rst & idle & cpu_rd & !cpu_wr & hit) ? v_line[off*DATA_W +: DATA_W] : '0;
  assign word_we = !rst & idle & cpu_wr & hit;
  assign line_we = ack & in_fill;
  assign clr_dirty = ack & in_wb;
  assign miss_cnt = miss_cnt_q;
  always_comb begin
    state_d = idle ? (miss ? (v_valid & v_dirty ? DC_WB : DC_FILL) : DC_IDLE)
                   : (ack ? (in_wb ? DC_FILL : DC_IDLE) : state_q);
    gap_d = clr_dirty;
    miss_cnt_d = (miss && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? DC_IDLE : state_d;
    gap_q <= !rst & gap_d;
    miss_cnt_q <= rst ? '0 : miss_cnt_d;
  end
  dcache_dm_wb_array u_array (
    .clk(clk), .rst(rst), .idx(idx),
    .rd_tag(v_tag), .rd_valid(v_valid), .rd_dirty(v_dirty), .rd_line(v_line),
    .line_we(line_we), .line_tag(tag), .line_data(mem_rline),
    .word_we(word_we), .word_off(off), .word_data(cpu_wdata),
    .clr_dirty(clr_dirty)
  );
endmodule
